cbus_mem_responder: RTL
=======================

CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024: memory depth in 32-bit words; power of two.
REQ-002 Parameter LATENCY, default 2: idle cycles between request accept and first data beat; range 0..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 cbus_req  input  cbus_req_t  initiator request: valid, is_write, size, addr, strobe, data, len.
REQ-006 cbus_resp  output  cbus_resp_t  responder reply: ready (one pulse per beat), last (final beat), data (read word).

Function
REQ-007 FSM states: IDLE, WAIT, BURST, DONE.
REQ-008 IDLE + cbus_req.valid:
- latch base word index addr[log2(MEM_WORDS)+1:2] as ptr
- latch is_write
- latch beats = len+1 (MLEN1..MLEN16 -> 1..16)
- clear beat counter
- load latency counter with LATENCY
- go WAIT, or go BURST if LATENCY==0.
REQ-009 WAIT: decrement latency counter each cycle; enter BURST the cycle after it reaches 0.
REQ-010 BURST: cbus_resp.ready=1 every cycle, giving one beat per cycle with no wait states inside a burst.
REQ-011 Read beat: cbus_resp.data = mem[ptr], combinational read of the current pointer.
REQ-012 Write beat:
- each byte lane i with strobe[i]=1 takes cbus_req.data byte i into mem[ptr] at the clock edge
- lanes with strobe[i]=0 keep their value
- cbus_resp.data=0.
REQ-013 After each beat, ptr increments by 1 modulo MEM_WORDS (wrap to 0), and the beat counter increments.
REQ-014 cbus_resp.last=1 exactly on the beat where beat counter == beats-1; the FSM then goes to DONE.
REQ-015 DONE: all outputs 0; request ignored; next state IDLE. A new request is therefore accepted no earlier than 2 cycles after last.
REQ-016 cbus_req.valid low during WAIT or BURST: abort.
- no write in that cycle
- outputs 0
- return to IDLE next cycle
REQ-017 Outside BURST: ready=0, last=0, data=0.
REQ-018 cbus_req.size is ignored; every beat is a full word, and byte selection on writes is by strobe only.
REQ-019 Request fields other than data and strobe are sampled only in IDLE; changes during a burst have no effect.
REQ-020 Address bits above log2(MEM_WORDS)+1 are ignored (aliasing).
REQ-021 Latency, LATENCY=L: first beat L+1 cycles after the accept edge; a burst of N beats occupies N consecutive cycles.

Reset
REQ-022 resetn=0 at a clock edge:
- FSM to IDLE
- counters, ptr, beats cleared
- cbus_resp all zero from the following cycle
REQ-023 Reset mid-burst aborts the transfer with no further memory writes; memory contents are not cleared by reset.
REQ-024 The first request is accepted on the first edge with resetn=1 and valid=1.

Structure
REQ-025 Shared package: cbus_req_t, cbus_resp_t, msize/mlen enums, and a responder state enum (IDLE/WAIT/BURST/DONE).
REQ-026 Storage is one sub-module cbus_mem_array: MEM_WORDS x 32, async read, sync byte-enable write, no reset.
REQ-027 FSM, counters and pointer reside in cbus_mem_responder.

Verification
REQ-028 Single read, LATENCY=2:
- preload mem[4]=0x2400_0001
- req addr=0x10, len=MLEN1
- required: ready=last=1 with data=0x2400_0001 three cycles after accept; single pulse.
REQ-029 Two-beat read:
- preload mem[8]=A, mem[9]=B
- addr=0x20, len=MLEN2
- required: two consecutive ready beats, data A then B; last only on B.
REQ-030 Byte-strobe write then read:
- mem[3]=0x1122_3344; write addr=0x0C, data=0xAABB_CCDD, strobe=4'b0101, len=MLEN1
- read back: 0x11BB_33DD.
REQ-031 Wrap, MEM_WORDS=1024:
- read addr=0xFFC, len=MLEN2
- required: beats from mem[1023] then mem[0]; last on second beat.
REQ-032 Reset mid-burst:
- 16-beat write; resetn=0 after beat 5
- required: only words 0..4 modified, outputs 0 next cycle
- new read after reset returns the stored data.
REQ-033 Back-to-back:
- valid held high through last and re-presented
- required: DONE gap, with next accept exactly 2 cycles after last and no duplicate beat.

Source files
------------

// File: rtl/cbus_mem_responder_pkg.sv
// Shared request/response types for the cbus memory responder and its callers.
package cbus_mem_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_e;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } mlen_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } resp_state_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_e      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_e       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Encoded length is beats-1; widen so 16 beats fits.
  function automatic logic [4:0] mlen_beats(input mlen_e len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/cbus_mem_array.sv
// Word-addressed 32-bit storage with asynchronous read and per-byte write enables.
module cbus_mem_array #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One byte-wide array per lane keeps each lane a single-writer memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// Burst memory responder on cbus: fixed start latency, then one beat per cycle.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  cbus_req,
  output cbus_resp_t cbus_resp
);

  localparam int AW = $clog2(MEM_WORDS);

  resp_state_e   state_reg;
  logic [AW-1:0] ptr_reg;
  logic          is_write_reg;
  logic [4:0]    beats_reg;
  logic [4:0]    beat_cnt_reg;
  logic [3:0]    lat_cnt_reg;

  logic          beat;
  logic          last_beat;
  logic          wr_en;
  logic [31:0]   rd_data;

  // A beat only happens while the initiator keeps valid up; dropping it aborts.
  assign beat      = (state_reg == BURST) && cbus_req.valid;
  assign last_beat = beat && (beat_cnt_reg == beats_reg - 5'd1);
  assign wr_en     = beat && is_write_reg && resetn;

  always_comb begin
    cbus_resp       = '0;
    cbus_resp.ready = beat;
    cbus_resp.last  = last_beat;
    cbus_resp.data  = (beat && !is_write_reg) ? rd_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      is_write_reg <= 1'b0;
      beats_reg    <= '0;
      beat_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cbus_req.valid) begin
            ptr_reg      <= cbus_req.addr[AW+1:2];
            is_write_reg <= cbus_req.is_write;
            beats_reg    <= mlen_beats(cbus_req.len);
            beat_cnt_reg <= '0;
            lat_cnt_reg  <= 4'(LATENCY);
            state_reg    <= (LATENCY == 0) ? BURST : WAIT;
          end
        end
        WAIT: begin
          if (!cbus_req.valid) begin
            state_reg <= IDLE;
          end else if (lat_cnt_reg == 4'd0) begin
            state_reg <= BURST;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        BURST: begin
          if (!cbus_req.valid) begin
            state_reg <= IDLE;
          end else begin
            ptr_reg      <= ptr_reg + 1'b1;
            beat_cnt_reg <= beat_cnt_reg + 5'd1;
            if (last_beat) begin
              state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  cbus_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .be    (cbus_req.strobe),
    .addr  (ptr_reg),
    .wdata (cbus_req.data),
    .rdata (rd_data)
  );

  // Size and out-of-range address bits carry no meaning for this responder.
  logic unused_req_bits;
  assign unused_req_bits = ^{cbus_req.size, cbus_req.addr[31:AW+2], cbus_req.addr[1:0]};

endmodule
